// File: rtl/multicycle_control_if.sv
// Datapath control bus between the multicycle control FSM (master) and the
// shared ALU / register file / unified memory datapath (slave).
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_err;

  // Handshake: the memory strobe (mem_read/mem_write) is the request and is
  // held until mem_ready is sampled high on a rising edge; the access
  // completes in that cycle and no further handshake state is kept.
  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, mem_err
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, mem_err
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM (R-format, lw, sw, beq; j when MC_CTRL_JUMP_EN
// is defined) with a bounded memory-ready wait in every memory state.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_control_if.master bus,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
`ifdef MC_CTRL_JUMP_EN
    BRANCH    = 4'd8,
    JUMP      = 4'd9
`else
    BRANCH    = 4'd8
`endif
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [5:0] OP_J   = 6'b000010;
`endif
  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt;
  logic       is_store;
  logic       mem_state;
  logic       mem_wait;
  logic       timeout;
  logic       illegal;

  // The zero flag is consumed by the datapath (ANDed with pc_write_cond).
  logic       unused_zero;
  assign unused_zero = bus.zero;

  always_comb begin
    mem_state = (state_q == FETCH) || (state_q == MEM_READ) ||
                (state_q == MEM_WRITE);
  end

  assign mem_wait = mem_state && !bus.mem_ready;
  assign timeout  = (TIMEOUT_LIM != 8'd0) && mem_wait &&
                    (wait_cnt == TIMEOUT_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      wait_cnt <= 8'd0;
      is_store <= 1'b0;
    end else begin
      state_q <= state_d;
      // A timeout out of FETCH stays in FETCH, so it must clear explicitly.
      if ((state_d != state_q) || timeout) begin
        wait_cnt <= 8'd0;
      end else if (mem_wait && (wait_cnt != 8'hff)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      // opcode is only trusted in DECODE; remember lw vs sw for MEM_ADDR.
      if (state_q == DECODE) begin
        is_store <= (bus.opcode == OP_SW);
      end
    end
  end

  always_comb begin
    state_d = FETCH;
    illegal = 1'b0;
    case (state_q)
      FETCH:     state_d = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_R:         state_d = R_EXEC;
          OP_BEQ:       state_d = BRANCH;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         state_d = JUMP;
`endif
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR:  state_d = is_store ? MEM_WRITE : MEM_READ;
      MEM_READ:  state_d = bus.mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = bus.mem_ready ? FETCH : MEM_WRITE;
      R_EXEC:    state_d = R_WB;
      default:   state_d = FETCH;
    endcase
    if (timeout) begin
      state_d = FETCH;
    end
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = 2'b00;
    bus.pc_source     = 2'b00;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;
    bus.mem_err       = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE: begin
        bus.alu_src_b  = 2'b11;
        bus.illegal_op = illegal;
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
      end
      MEM_WRITE: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
      end
      R_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = 2'b01;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
        bus.instr_done    = 1'b1;
      end
`ifdef MC_CTRL_JUMP_EN
      JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        bus.instr_done = 1'b1;
      end
`endif
      default: begin
        bus.alu_src_b = 2'b00;
      end
    endcase
    // An abandoned access must not load IR/PC, write memory or retire.
    if (timeout) begin
      bus.mem_err    = 1'b1;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.instr_done = 1'b0;
    end
    if (rst) begin
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.i_or_d        = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.pc_source     = 2'b00;
      bus.instr_done    = 1'b0;
      bus.illegal_op    = 1'b0;
      bus.mem_err       = 1'b0;
    end
  end

  assign state = rst ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-accurate scoreboard bench for multicycle_control (MEM_TIMEOUT=3);
// honours MC_CTRL_JUMP_EN for the opcode 000010 expectations.
module tb_multicycle_control;

  localparam int W = 23;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic       clk;
  logic       rst;
  logic [3:0] state;
  int         n_checks;
  int         n_errors;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  multicycle_control_if bus ();

  multicycle_control #(.MEM_TIMEOUT(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .state (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs for a state, packed as
  // {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
  //  pc_source, instr_done, illegal_op, mem_err}
  function automatic logic [W-1:0] exp_vec(input logic [3:0] st,
                                           input logic mr, input logic to,
                                           input logic ill);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, id, ie, me;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, id, ie, me} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      4'd0: begin mrd = 1; asb = 2'b01; irw = mr & ~to; pw = mr & ~to; me = to; end
      4'd1: begin asb = 2'b11; ie = ill; end
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mrd = 1; iod = 1; me = to; end
      4'd4: begin rw = 1; m2r = 1; id = 1; end
      4'd5: begin mwr = ~to; iod = 1; id = mr & ~to; me = to; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rd = 1; id = 1; end
      4'd8: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; id = 1; end
      4'd9: begin pw = 1; psrc = 2'b10; id = 1; end
      default: ;
    endcase
    return {st, pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc,
            id, ie, me};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input string tag, input logic [3:0] st, input logic mr,
                      input logic [5:0] op, input logic to = 1'b0,
                      input logic ill = 1'b0, input logic r = 1'b0);
    @(posedge clk);
    #1;
    rst           = r;
    bus.mem_ready = mr;
    bus.opcode    = op;
    bus.zero      = 1'($urandom_range(0, 1));
    exp_q.push_back(r ? '0 : exp_vec(st, mr, to, ill));
    tag_q.push_back(tag);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rnd_op();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic fetch(input logic [5:0] op, input int waits);
    for (int i = 0; i < waits; i++) step("fetch_wait", 4'd0, 1'b0, op);
    step("fetch", 4'd0, 1'b1, op);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    string        t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {state, bus.pc_write, bus.pc_write_cond, bus.i_or_d,
                bus.mem_read, bus.mem_write, bus.ir_write, bus.mem_to_reg,
                bus.reg_dst, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_source, bus.instr_done, bus.illegal_op,
                bus.mem_err}, e);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.opcode    = 6'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    step("reset", 4'd0, 1'b1, OP_LW, 1'b0, 1'b0, 1'b1);

    // R-format, memory always ready; opcode scrambled after DECODE
    fetch(OP_R, 0);
    step("r_decode", 4'd1, 1'b1, OP_R);
    step("r_exec", 4'd6, rnd_bit(), rnd_op());
    step("r_wb", 4'd7, rnd_bit(), rnd_op());

    // lw with two MEM_READ wait cycles
    fetch(OP_LW, 0);
    step("lw_decode", 4'd1, 1'b1, OP_LW);
    step("lw_addr", 4'd2, rnd_bit(), rnd_op());
    step("lw_read_wait", 4'd3, 1'b0, rnd_op());
    step("lw_read_wait", 4'd3, 1'b0, rnd_op());
    step("lw_read", 4'd3, 1'b1, rnd_op());
    step("lw_wb", 4'd4, rnd_bit(), rnd_op());

    // sw, random fetch wait below the limit
    fetch(OP_SW, $urandom_range(0, 2));
    step("sw_decode", 4'd1, 1'b1, OP_SW);
    step("sw_addr", 4'd2, rnd_bit(), rnd_op());
    step("sw_write", 4'd5, 1'b1, rnd_op());

    // beq, taken and not taken (zero is random every cycle)
    for (int k = 0; k < 2; k++) begin
      fetch(OP_BEQ, $urandom_range(0, 2));
      step("beq_decode", 4'd1, 1'b1, OP_BEQ);
      step("beq_branch", 4'd8, rnd_bit(), rnd_op());
    end

    // sw timeout: MEM_WRITE held 4 cycles, error on the 4th
    fetch(OP_SW, 0);
    step("swto_decode", 4'd1, 1'b1, OP_SW);
    step("swto_addr", 4'd2, 1'b1, rnd_op());
    for (int i = 0; i < 3; i++) step("swto_wait", 4'd5, 1'b0, rnd_op());
    step("swto_err", 4'd5, 1'b0, rnd_op(), 1'b1);

    // fetch timeout returns to FETCH, then a fetch right at the limit succeeds
    for (int i = 0; i < 3; i++) step("fetchto_wait", 4'd0, 1'b0, OP_R);
    step("fetchto_err", 4'd0, 1'b0, OP_R, 1'b1);
    fetch(OP_R, 3);
    step("r2_decode", 4'd1, 1'b1, OP_R);
    step("r2_exec", 4'd6, 1'b0, rnd_op());
    step("r2_wb", 4'd7, 1'b0, rnd_op());

    // MEM_READ timeout
    fetch(OP_LW, 1);
    step("lwto_decode", 4'd1, 1'b1, OP_LW);
    step("lwto_addr", 4'd2, 1'b0, rnd_op());
    for (int i = 0; i < 3; i++) step("lwto_wait", 4'd3, 1'b0, rnd_op());
    step("lwto_err", 4'd3, 1'b0, rnd_op(), 1'b1);

    // opcode 000010
    fetch(OP_J, 0);
`ifdef MC_CTRL_JUMP_EN
    step("j_decode", 4'd1, 1'b1, OP_J);
    step("j_jump", 4'd9, rnd_bit(), rnd_op());
`else
    step("j_illegal", 4'd1, 1'b1, OP_J, 1'b0, 1'b1);
`endif

    // other unsupported opcodes
    fetch(6'b001000, 0);
    step("ill_addi", 4'd1, 1'b1, 6'b001000, 1'b0, 1'b1);
    fetch(6'b111111, 0);
    step("ill_ones", 4'd1, 1'b0, 6'b111111, 1'b0, 1'b1);

    // reset during MEM_READ, then counter must start from 0 again
    fetch(OP_LW, 0);
    step("rst_decode", 4'd1, 1'b1, OP_LW);
    step("rst_addr", 4'd2, 1'b1, rnd_op());
    step("rst_read_wait", 4'd3, 1'b0, rnd_op());
    step("rst_read_wait", 4'd3, 1'b0, rnd_op());
    step("rst_in_read", 4'd0, 1'b1, rnd_op(), 1'b0, 1'b0, 1'b1);
    fetch(OP_LW, 3);
    step("rst_lw_decode", 4'd1, 1'b1, OP_LW);
    step("rst_lw_addr", 4'd2, 1'b1, rnd_op());
    step("rst_lw_read", 4'd3, 1'b1, rnd_op());
    step("rst_lw_wb", 4'd4, 1'b1, rnd_op());

    // reset while FETCH has accumulated wait cycles clears the counter
    step("fetch_wait", 4'd0, 1'b0, OP_R);
    step("fetch_wait", 4'd0, 1'b0, OP_R);
    step("rst_in_fetch", 4'd0, 1'b0, OP_R, 1'b0, 1'b0, 1'b1);
    fetch(OP_R, 3);
    step("r3_decode", 4'd1, 1'b1, OP_R);
    step("r3_exec", 4'd6, 1'b1, rnd_op());
    step("r3_wb", 4'd7, 1'b1, rnd_op());
    step("final_fetch", 4'd0, 1'b1, OP_BEQ);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS control FSM that sequences the shared ALU/adder-subtracter, register file and unified instruction/data memory, one instruction per 3–5+ cycles. It decodes `opcode` and emits per-state datapath controls: mux selects, write enables, memory strobes and `alu_op`. `alu_op` feeds the existing ALU-control mapping (00 add, 01 subtract, 10 funct-decoded). Supported instructions: R-format, lw, sw, beq, and j when configured. The FSM waits on a memory ready handshake and bounds each memory access with a timeout.

## Interface
- `MEM_TIMEOUT`, default 15: maximum wait cycles with `mem_ready` low in any memory state. 0 disables the timeout. Range 0–255.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completed the current read/write this cycle.
- `pc_write`, `pc_write_cond` out 1: PC write enable; conditional PC write, datapath ANDs with `zero`.
- `i_or_d` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`, `ir_write` out 1: memory strobes; IR load.
- `mem_to_reg`, `reg_dst`, `reg_write` out 1: register write-back controls.
- `alu_src_a` out 1: 0 = PC, 1 = A.
- `alu_src_b` out 2: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_op` out 2: 00 add, 01 sub, 10 funct.
- `pc_source` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `instr_done` out 1: high in the final cycle of each completed instruction.
- `illegal_op` out 1: high in DECODE for an unsupported opcode.
- `mem_err` out 1: high in the cycle a memory timeout fires.
- `state` out 4: current state code, for debug.

## Operation
- States and codes:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4
  - MEM_WRITE = 5, R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9
  - Codes 10–15 are unreachable and go to FETCH.
- Opcode decode:
  - R-format = 000000
  - lw = 100011
  - sw = 101011
  - beq = 000100
  - j = 000010 (only with the macro; see Configuration)
- Outputs per state. Any output not listed is 0.
  - FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write`=`pc_write`=`mem_ready`.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target to ALUOut).
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - MEM_READ: `mem_read`=1, `i_or_d`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - MEM_WRITE: `mem_write`=1, `i_or_d`=1.
  - R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - JUMP: `pc_write`=1, `pc_source`=10.
- Transitions:
  - FETCH → DECODE on `mem_ready`, else stay.
  - DECODE: lw/sw → MEM_ADDR; R → R_EXEC; beq → BRANCH; j → JUMP; other → FETCH with `illegal_op`=1.
  - MEM_ADDR → MEM_READ (lw) or MEM_WRITE (sw).
  - MEM_READ → MEM_WB on `mem_ready`, else stay.
  - MEM_WRITE → FETCH on `mem_ready`, else stay.
  - R_EXEC → R_WB.
  - MEM_WB, R_WB, BRANCH, JUMP → FETCH.
- `instr_done` is high in: MEM_WB, R_WB, BRANCH, JUMP, and MEM_WRITE when `mem_ready`=1.
- Wait counter: 8 bits.
  - Cleared on every state change.
  - Increments each cycle a memory state (FETCH, MEM_READ, MEM_WRITE) holds with `mem_ready`=0.
  - When the counter equals `MEM_TIMEOUT` (nonzero) and `mem_ready`=0: `mem_err`=1, next state FETCH. That cycle `ir_write`, `pc_write`, `mem_write` and `instr_done` are forced to 0.
  - `mem_ready`=1 in the same cycle the limit is reached completes the access normally, with no error.

## Timing
- Moore outputs, except FETCH `ir_write`/`pc_write` and MEM_WRITE `instr_done`, which combinationally follow `mem_ready`.
- Cycles per instruction with zero wait:
  - R-format 4
  - lw 5
  - sw 4
  - beq 3
  - j 3
- Each memory wait cycle adds 1 cycle.
- `opcode` is sampled only in DECODE.
- Reset:
  - While `rst`=1, every output is forced to 0 (`state`=0).
  - The first edge with `rst`=1 sets state FETCH and counter 0.
  - Reset mid-instruction abandons it; no write strobe is asserted in the reset cycle.

## Configuration
- `MC_CTRL_JUMP_EN` defined: opcode 000010 decodes to the JUMP state.
- Undefined: the JUMP state is absent, and 000010 is illegal (`illegal_op`=1 in DECODE, return to FETCH).

## Test plan
- R-format (000000), `mem_ready` always 1:
  - State sequence 0 → 1 → 6 → 7 → 0.
  - `alu_op`=10 in R_EXEC; `reg_write`=`reg_dst`=1 in R_WB; `instr_done` exactly once.
- lw (100011) with `mem_ready` low for 2 cycles in MEM_READ:
  - Sequence 0, 1, 2, 3, 3, 3, 4, 0 (7 cycles).
  - `mem_to_reg`=1 in MEM_WB.
- beq (000100) with `zero`=1, then with `zero`=0:
  - Both take 3 cycles.
  - `pc_write_cond`=1, `alu_op`=01, `pc_source`=01 in BRANCH.
- `MEM_TIMEOUT`=3, sw with `mem_ready` held 0:
  - MEM_WRITE held 4 cycles; `mem_err`=1 on the 4th, with `mem_write`=0 and `instr_done`=0 that cycle.
  - Next state FETCH.
- Opcode 000010:
  - With `MC_CTRL_JUMP_EN`: sequence 0 → 1 → 9 → 0, with `pc_source`=10.
  - Without it: `illegal_op`=1 in DECODE, then FETCH.
- `rst` asserted during MEM_READ:
  - All outputs 0 in that cycle.
  - State 0 next cycle; counter cleared.
